// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH qualified serial bits into a held word
// with a one-cycle valid strobe. Define SIPO_PARITY_EN to append and check an even parity bit.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sen,
  input  logic             clr,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  output logic             busy,
  output logic             perr
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int             CNT_W    = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] done_word;
  logic             done;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {s[WIDTH-2:0], b};
    end else begin
      r = {b, s[WIDTH-1:1]};
    end
    return r;
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction

  // Next-state for the shift register and bit counter; clr outranks sen.
  always_comb begin
    shifted   = shift_in(shreg, sin);
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done      = 1'b0;
`ifdef SIPO_PARITY_EN
    // The final frame bit is parity: the data word is already complete in shreg.
    done_word = shreg;
`else
    done_word = shifted;
`endif
    if (clr) begin
      shreg_nxt = '0;
      cnt_nxt   = CNT_ZERO;
    end else if (sen) begin
      if (cnt == CNT_LAST) begin
        done      = 1'b1;
        cnt_nxt   = CNT_ZERO;
        shreg_nxt = '0;
      end else begin
        cnt_nxt   = cnt + CNT_ONE;
        shreg_nxt = shifted;
      end
    end else begin
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
    end
  end

  // Registered state and outputs; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= CNT_ZERO;
      pout   <= '0;
      pvalid <= 1'b0;
      busy   <= 1'b0;
    end else begin
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      pvalid <= done;
      busy   <= (cnt_nxt != CNT_ZERO);
      if (done) begin
        pout <= done_word;
      end else begin
        pout <= pout;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity flag updates only on completion and holds until the next word or rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (done) begin
      perr <= even_parity(shreg) ^ sin;
    end else begin
      perr <= perr;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Randomized + directed bench for sipo_rx: two instances (MSB-first and LSB-first) share
// the inputs and are compared against a bit-queue reference model each cycle.
module tb_sipo_rx;

`ifdef SIPO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0, sin = 1'b0, sen = 1'b0, clr = 1'b0;
  logic [3:0] pout_m, pout_l;
  logic       pvalid_m, pvalid_l, busy_m, busy_l, perr_m, perr_l;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  bit         q[$];
  logic [3:0] exp_m = 4'd0, exp_l = 4'd0;
  logic       exp_pv = 1'b0, exp_perr = 1'b0;
  int         pv_seen = 0;

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sen(sen), .clr(clr),
    .pout(pout_m), .pvalid(pvalid_m), .busy(busy_m), .perr(perr_m));

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sen(sen), .clr(clr),
    .pout(pout_l), .pvalid(pvalid_l), .busy(busy_l), .perr(perr_l));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic e, input logic d);
    int ones;
    if (r) begin
      q.delete();
      exp_m = 4'd0; exp_l = 4'd0; exp_pv = 1'b0; exp_perr = 1'b0;
    end else if (c) begin
      q.delete();
      exp_pv = 1'b0;
    end else begin
      exp_pv = 1'b0;
      if (e) begin
        q.push_back(d);
        if (q.size() == FRAME) begin
          ones = 0;
          for (int i = 0; i < 4; i++) begin
            exp_m[3-i] = q[i];
            exp_l[i]   = q[i];
          end
          for (int i = 0; i < FRAME; i++) ones += int'(q[i]);
`ifdef SIPO_PARITY_EN
          exp_perr = (ones % 2) != 0;
`endif
          exp_pv = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic d);
    rst = r; clr = c; sen = e; sin = d;
    @(posedge clk);
    model_edge(r, c, e, d);
    #1;
    check("pout_msb", 32'(pout_m), 32'(exp_m));
    check("pout_lsb", 32'(pout_l), 32'(exp_l));
    check("pvalid_msb", 32'(pvalid_m), 32'(exp_pv));
    check("pvalid_lsb", 32'(pvalid_l), 32'(exp_pv));
    check("busy", 32'(busy_m), 32'(q.size() != 0));
    check("busy_lsb", 32'(busy_l), 32'(q.size() != 0));
    check("perr", 32'(perr_m), 32'(exp_perr));
    if (pvalid_m) pv_seen++;
  endtask

  // Sends a 4-bit word first bit = w[3]; appends correct parity when enabled.
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w[i]);
`ifdef SIPO_PARITY_EN
    step(1'b0, 1'b0, 1'b1, ^w);
`endif
  endtask

  initial begin
    int r;
    // Reset, with sen toggling during reset
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("reset_pout", 32'(pout_m), 32'd0);
    check("reset_busy", 32'(busy_m), 32'd0);

    // Basic word in both bit orders
    pv_seen = 0;
    send_word(4'b1011);
    check("basic_msb", 32'(pout_m), 32'h0000000b);
    check("basic_lsb", 32'(pout_l), 32'h0000000d);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_pv_count", 32'(pv_seen), 32'd1);

    // Gap in sen mid-word
    pv_seen = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("gap_no_pv", 32'(pv_seen), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef SIPO_PARITY_EN
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif
    check("gap_word", 32'(pout_m), 32'h00000005);

    // Back-to-back words
    send_word(4'b1101);
    check("b2b_first", 32'(pout_m), 32'h0000000d);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("b2b_busy", 32'(busy_m), 32'd1);
    for (int i = 2; i >= 0; i--) step(1'b0, 1'b0, 1'b1, (i == 1) ? 1'b1 : 1'b0);
`ifdef SIPO_PARITY_EN
    step(1'b0, 1'b0, 1'b1, 1'b1);
`endif
    check("b2b_second", 32'(pout_m), 32'h00000002);

    // clr aborts a partial word, sen bit on clr edge is dropped
    pv_seen = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_word(4'b1111);
    check("clr_pv_count", 32'(pv_seen), 32'd1);
    check("clr_word", 32'(pout_m), 32'h0000000f);

    // rst mid-word
    pv_seen = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mid_pout", 32'(pout_m), 32'd0);
    check("rst_mid_pv", 32'(pv_seen), 32'd0);

`ifdef SIPO_PARITY_EN
    // Parity good then bad, flag holds until next word
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b0, 1'b1, 1'(4'b1011 >> i));
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("par_ok", 32'(perr_m), 32'd0);
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b0, 1'b1, 1'(4'b1011 >> i));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("par_bad", 32'(perr_m), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("par_hold", 32'(perr_m), 32'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      step((r < 2) ? 1'b1 : 1'b0, (r >= 2 && r < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
